osd_trace_depacketization: RTL
==============================

# osd_trace_depacketization

Receive side of the trace event packet protocol. Accepts DII flits from the debug interconnect, filters for trace event packets addressed to this module, and reassembles the WIDTH-bit trace sample from 16-bit payload words. Also decodes overflow packets and presents samples and overflow notices on a valid/ready stream. Sits between the debug ring endpoint and trace consumers: on-chip trace sinks, loopback verification of the trace module, and host-bridge logic.

## Interface
Parameters:
- WIDTH, 166, trace sample width in bits. Payload length is NW = ceil(WIDTH/16) words.

Ports:
- clk  in  1  clock; all logic is posedge-clk.
- rst  in  1  reset. Synchronous and active-high.
- id  in  16  this module's DII address.
- debug_in  in  dii_flit  incoming flit: valid, last, data[15:0].
- debug_in_ready  out  1  flit accepted when debug_in.valid && debug_in_ready.
- trace_data  out  WIDTH  reassembled sample.
- trace_overflow  out  1  current output is an overflow notice, not a sample.
- trace_overflow_count  out  16  dropped-sample count. Valid when trace_overflow=1.
- trace_valid  out  1  output valid.
- trace_ready  in  1  consumer accepts the output.
- protocol_err  out  1  one-cycle pulse when a malformed packet is discarded.
- src_filter  in  16  present only with OSD_TRACE_DEPKT_SRCFILTER_EN.

## Operation
Packet format:
- flit0 = dest.
- flit1 = src.
- flit2 = flags: [15:14] type, [13:10] type_sub.
- Then the payload.
- Trace packet: type=2'b10, type_sub=0, exactly NW payload words, least-significant word first. Bits above WIDTH in the last word are ignored.
- Overflow packet: type=2'b10, type_sub=5, exactly 1 payload word, which is the dropped count.

States: DEST, SRC, FLAGS, PAYLOAD, DROP, OUT.
- DEST: accept flit0. If dest!=id, go to DROP; otherwise go to SRC. A flit with last=1 in DEST/SRC/FLAGS goes to DEST and pulses protocol_err (only if dest==id).
- SRC: latch src and go to FLAGS.
- FLAGS:
  - trace type → PAYLOAD with expected count NW.
  - overflow type → PAYLOAD with expected count 1.
  - any other type/sub → DROP, silently, with no error.
- PAYLOAD: shift each word into the assembly register at word index wcnt; increment wcnt.
  - last on word NW-1 (or 0 for overflow): go to OUT.
  - last on an earlier word: discard, pulse protocol_err, go to DEST.
  - Word NW-1 without last: go to DROP and pulse protocol_err.
- DROP: consume flits until last=1, then go to DEST.
- OUT: trace_valid=1 and debug_in_ready=0. On trace_ready, go to DEST.
- debug_in_ready = 1 in every state except OUT.
- Output registers (trace_data, trace_overflow, trace_overflow_count) change only on entry to OUT. They are stable while trace_valid=1.
- Payload word counter is ceil(log2(NW+1)) bits wide and is cleared on entry to PAYLOAD.

## Timing
- Reset values: state=DEST, trace_valid=0, trace_overflow=0, trace_overflow_count=0, trace_data=0, protocol_err=0. debug_in_ready is 1 from the first cycle after reset.
- Reset mid-packet abandons the packet. Remaining flits are then parsed as a new packet starting in DEST, and the upstream interconnect is responsible for packet alignment after reset.
- Latency: trace_valid rises the cycle after the last payload flit is accepted.
- OUT is one-deep: minimum packet-to-packet spacing is one cycle after the consumer handshake. No flit is accepted in the cycle trace_valid && trace_ready; the next flit is accepted the following cycle.
- trace_valid never drops without trace_ready.
- protocol_err is registered and asserts the cycle after the offending flit.
- An invalid input flit (valid=0) causes no state change in any state.

## Configuration
OSD_TRACE_DEPKT_SRCFILTER_EN:
- Defined: port src_filter exists. In SRC, if src_filter!=0 and src!=src_filter, go to DROP (no error).
- Undefined: the port is absent and all sources are accepted.

## Test plan
- WIDTH=166, id=0x0010: packet dest 0x0010, src 0x0005, flags 0x8000, 11 words 0x0001..0x000B → trace_valid one cycle after last flit. trace_data[15:0]=0x0001, trace_data[165:160]=0x0B & 0x3F. trace_overflow=0.
- Overflow packet flags 0x9400, payload 0x0007 → trace_valid=1, trace_overflow=1, trace_overflow_count=0x0007.
- Dest 0x0011 packet, 14 flits → all consumed with debug_in_ready=1. No trace_valid, no protocol_err.
- Trace packet with last on payload word 4 → protocol_err pulse, no output. An immediately following valid packet decodes correctly.
- Back-pressure: trace_ready=0 for 20 cycles while a second packet is pending → debug_in_ready=0 throughout. First sample held stable. Second sample output after release with no flit loss.
- With macro, src_filter=0x0005: packet from src 0x0006 dropped, packet from src 0x0005 delivered. Assert rst during PAYLOAD → trace_valid=0 next cycle, state DEST.

Source files
------------

// File: rtl/osd_trace_depacketization.sv
// osd_trace_depacketization: filters DII trace/overflow packets for this id and rebuilds WIDTH-bit samples.
// Optional source filtering is enabled by defining OSD_TRACE_DEPKT_SRCFILTER_EN.
module osd_trace_depacketization #(
  parameter int WIDTH = 166
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      id_i,
  input  logic             debug_in_valid_i,
  input  logic             debug_in_last_i,
  input  logic [15:0]      debug_in_data_i,
  output logic             debug_in_ready_o,
  output logic [WIDTH-1:0] trace_data_o,
  output logic             trace_overflow_o,
  output logic [15:0]      trace_overflow_count_o,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic             protocol_err_o
`ifdef OSD_TRACE_DEPKT_SRCFILTER_EN
  ,
  input  logic [15:0]      src_filter_i
`endif
);
  localparam int NW = (WIDTH + 15) / 16;
  localparam int CW = $clog2(NW + 1);
  localparam logic [CW-1:0] LAST = CW'(NW - 1);
  typedef enum logic [2:0] {DEST, SRC, FLAGS, PAYLOAD, DROP, OUT} state_t;
  state_t state_q;
  logic [CW-1:0] wcnt_q;
  logic ovf_q;
  logic [WIDTH-1:0] asm_q, asm_d, trace_data_q;
  logic trace_overflow_q, protocol_err_q;
  logic [15:0] trace_overflow_count_q;
  logic fire, last_word;
  assign debug_in_ready_o = state_q != OUT;
  assign trace_valid_o = state_q == OUT;
  assign trace_data_o = trace_data_q;
  assign trace_overflow_o = trace_overflow_q;
  assign trace_overflow_count_o = trace_overflow_count_q;
  assign protocol_err_o = protocol_err_q;
  assign fire = debug_in_valid_i && debug_in_ready_o;
  assign last_word = wcnt_q == (ovf_q ? '0 : LAST);
  // Current payload word merged into its slot; bits beyond WIDTH fall away.
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < WIDTH; i++)
      if (wcnt_q == CW'(i / 16)) asm_d[i] = debug_in_data_i[i % 16];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DEST;
      wcnt_q <= '0;
      ovf_q <= 1'b0;
      asm_q <= '0;
      trace_data_q <= '0;
      trace_overflow_q <= 1'b0;
      trace_overflow_count_q <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      protocol_err_q <= 1'b0;
      case (state_q)
        DEST: if (fire) begin
          state_q <= debug_in_last_i ? DEST : (debug_in_data_i == id_i ? SRC : DROP);
          protocol_err_q <= debug_in_last_i && debug_in_data_i == id_i;
        end
        SRC: if (fire) begin
          state_q <= debug_in_last_i ? DEST : FLAGS;
          protocol_err_q <= debug_in_last_i;
`ifdef OSD_TRACE_DEPKT_SRCFILTER_EN
          if (!debug_in_last_i && src_filter_i != '0 && debug_in_data_i != src_filter_i) state_q <= DROP;
`endif
        end
        FLAGS: if (fire) begin
          wcnt_q <= '0;
          ovf_q <= debug_in_data_i[15:10] == 6'b100101;
          protocol_err_q <= debug_in_last_i;
          state_q <= debug_in_last_i ? DEST :
                     (debug_in_data_i[15:10] == 6'b100000 || debug_in_data_i[15:10] == 6'b100101) ? PAYLOAD : DROP;
        end
        PAYLOAD: if (fire) begin
          asm_q <= asm_d;
          wcnt_q <= wcnt_q + 1'b1;
          if (last_word && debug_in_last_i) begin
            state_q <= OUT;
            trace_overflow_q <= ovf_q;
            if (ovf_q) trace_overflow_count_q <= debug_in_data_i;
            else trace_data_q <= asm_d;
          end else if (last_word || debug_in_last_i) begin
            state_q <= debug_in_last_i ? DEST : DROP;
            protocol_err_q <= 1'b1;
          end
        end
        DROP: if (fire && debug_in_last_i) state_q <= DEST;
        OUT: if (trace_ready_i) state_q <= DEST;
        default: state_q <= DEST;
      endcase
    end
  end
endmodule
